// File: rtl/prog_clk_divider.sv
// Programmable clock divider: runtime-loadable square wave, tick strobe, wrapping
// display phase index (binary and one-hot), with a one-shot mode for timed delays.
module prog_clk_divider #(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned DIV_DEFAULT = 131072,
  parameter int unsigned NUM_PHASES  = 2,
  parameter int unsigned PHASE_W     = $clog2(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      div_in,
  input  logic                  oneshot,
  output logic                  clk_div,
  output logic                  tick,
  output logic [PHASE_W-1:0]    phase,
  output logic [NUM_PHASES-1:0] phase_onehot,
  output logic                  done,
  output logic [WIDTH-1:0]      div_q
);

  if (NUM_PHASES < 2) begin : gen_bad_phases
    $error("prog_clk_divider: NUM_PHASES must be >= 2");
  end

  if ((DIV_DEFAULT < 1) || (longint'(DIV_DEFAULT) > ((longint'(1) << WIDTH) - 1)))
  begin : gen_bad_div
    $error("prog_clk_divider: DIV_DEFAULT out of range 1..2^WIDTH-1");
  end

  typedef enum logic [0:0] {StRun, StHold} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic             terminal;
  logic [WIDTH-1:0] div_next;
  logic [PHASE_W-1:0] phase_next;

  // div_q is never 0, so div_q - 1 cannot underflow.
  assign terminal   = (cnt_q == (div_q - WIDTH'(1)));
  assign div_next   = (div_in == '0) ? WIDTH'(1) : div_in;
  assign phase_next = (phase == PHASE_W'(NUM_PHASES - 1)) ? '0 : phase + PHASE_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
      div_q   <= WIDTH'(DIV_DEFAULT);
      clk_div <= 1'b0;
      tick    <= 1'b0;
      phase   <= '0;
      done    <= 1'b0;
    end else if (load) begin
      // A load restarts the period; clk_div and phase carry over untouched.
      state_q <= StRun;
      cnt_q   <= '0;
      div_q   <= div_next;
      tick    <= 1'b0;
      done    <= 1'b0;
    end else begin
      tick <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (en) begin
            if (terminal) begin
              cnt_q   <= '0;
              clk_div <= ~clk_div;
              tick    <= 1'b1;
              phase   <= phase_next;
              if (oneshot) begin
                done    <= 1'b1;
                state_q <= StHold;
              end
            end else begin
              cnt_q <= cnt_q + WIDTH'(1);
            end
          end
        end
        StHold: begin
          done <= 1'b1;
        end
        default: state_q <= StRun;
      endcase
    end
  end

  always_comb begin
    phase_onehot = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      phase_onehot[i] = (phase == PHASE_W'(i));
    end
  end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: directed scenarios then random traffic, compared every
// cycle against a model that counts enabled cycles and derives toggles arithmetically.
module tb_prog_clk_divider;

  localparam int unsigned WIDTH   = 24;
  localparam int unsigned DEF_DIV = 37;
  localparam int unsigned NPH     = 4;
  localparam int unsigned PW      = $clog2(NPH);

  logic             clk = 1'b0;
  logic             reset, en, load, oneshot;
  logic [WIDTH-1:0] div_in;
  logic             clk_div, tick, done;
  logic [PW-1:0]    phase;
  logic [NPH-1:0]   phase_onehot;
  logic [WIDTH-1:0] div_q;

  int checks = 0;
  int errors = 0;

  prog_clk_divider #(
    .WIDTH      (WIDTH),
    .DIV_DEFAULT(DEF_DIV),
    .NUM_PHASES (NPH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .load        (load),
    .div_in      (div_in),
    .oneshot     (oneshot),
    .clk_div     (clk_div),
    .tick        (tick),
    .phase       (phase),
    .phase_onehot(phase_onehot),
    .done        (done),
    .div_q       (div_q)
  );

  always #5 clk = ~clk;

  // Model: period length, enabled cycles since the last load/reset, toggles since then,
  // and the clk_div/phase values captured at that load.
  longint m_d     = DEF_DIV;
  longint m_e     = 0;
  longint m_tog   = 0;
  bit     m_bclk  = 1'b0;
  longint m_bph   = 0;
  bit     m_hold  = 1'b0;
  bit     m_tick  = 1'b0;

  function automatic bit cur_clk();
    return m_bclk ^ m_tog[0];
  endfunction

  function automatic longint cur_phase();
    return (m_bph + m_tog) % NPH;
  endfunction

  task automatic model_update(bit r, bit l, bit e, bit os, logic [WIDTH-1:0] d);
    if (!r) begin
      m_d = DEF_DIV; m_e = 0; m_tog = 0; m_bclk = 0; m_bph = 0; m_hold = 0; m_tick = 0;
    end else if (l) begin
      m_bclk = cur_clk();
      m_bph  = cur_phase();
      m_d    = (d == 0) ? 1 : longint'(d);
      m_e = 0; m_tog = 0; m_hold = 0; m_tick = 0;
    end else if (e && !m_hold) begin
      m_e++;
      if (m_e % m_d == 0) begin
        m_tog++;
        m_tick = 1;
        if (os) m_hold = 1;
      end else begin
        m_tick = 0;
      end
    end else begin
      m_tick = 0;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NPH-1:0] oh;
    oh = '0;
    oh[cur_phase()] = 1'b1;
    chk("clk_div", 32'(clk_div), 32'(cur_clk()));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("phase", 32'(phase), 32'(cur_phase()));
    chk("phase_onehot", 32'(phase_onehot), 32'(oh));
    chk("done", 32'(done), 32'(m_hold));
    chk("div_q", 32'(div_q), 32'(m_d));
  endtask

  task automatic step(bit r, bit l, bit e, bit os, logic [WIDTH-1:0] d);
    reset = r; load = l; en = e; oneshot = os; div_in = d;
    @(posedge clk);
    model_update(r, l, e, os, d);
    #1;
    check_all();
  endtask

  task automatic run(int n, bit e, bit os);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, e, os, '0);
  endtask

  int ticks_seen;

  initial begin
    reset = 1'b0; load = 1'b0; en = 1'b0; oneshot = 1'b0; div_in = '0;

    // Defaults; reset overrides a simultaneous load and en.
    step(1'b0, 1'b1, 1'b1, 1'b0, 24'd9);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk("rst_div_q", 32'(div_q), DEF_DIV);
    chk("rst_onehot", 32'(phase_onehot), 32'h1);
    run(80, 1'b1, 1'b0);

    // Runtime load of 5: four ticks in the next 20 edges.
    step(1'b1, 1'b1, 1'b0, 1'b0, 24'd5);
    ticks_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, '0);
      ticks_seen += int'(tick);
    end
    chk("ticks_div5", 32'(ticks_seen), 32'd4);

    // Zero period behaves as 1.
    step(1'b1, 1'b1, 1'b1, 1'b0, 24'd0);
    run(6, 1'b1, 1'b0);

    // Full phase wrap with period 3.
    step(1'b1, 1'b1, 1'b1, 1'b0, 24'd3);
    run(13, 1'b1, 1'b0);

    // One-shot, HOLD ignores lowering oneshot, load releases.
    step(1'b1, 1'b1, 1'b1, 1'b1, 24'd8);
    run(9, 1'b1, 1'b1);
    run(20, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 24'd8);
    run(10, 1'b1, 1'b0);

    // Enable gap at cnt=3, then load on a terminal cycle, then reset mid-period.
    step(1'b1, 1'b1, 1'b1, 1'b0, 24'd5);
    run(3, 1'b1, 1'b0);
    run(10, 1'b0, 1'b0);
    run(3, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 24'd5);
    run(4, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 24'd5);
    run(3, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk("midrst_tick", 32'(tick), 32'd0);
    run(5, 1'b1, 1'b0);

    // Random traffic.
    begin
      bit os = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        bit r, l, e;
        logic [WIDTH-1:0] d;
        r = ($urandom_range(0, 499) != 0);
        l = ($urandom_range(0, 39) == 0);
        e = ($urandom_range(0, 99) < 85);
        if ($urandom_range(0, 59) == 0) os = ~os;
        d = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom_range(1, 2)) :
                                          WIDTH'($urandom_range(0, 12));
        step(r, l, e, os, d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
